// File: rtl/chain_mix_sequencer_pkg.sv
// Shared types and timing defaults for the mixer-chain sequencer.
// The latency helper is used by both the RTL checks and the bench.
package chain_mix_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StInject,
    StMix,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned LoadCyclesDef  = 4;
  localparam int unsigned InjCyclesDef   = 2;
  localparam int unsigned DrainCyclesDef = 4;

  // Start-sampling edge to the cycle that carries the done pulse.
  function automatic int unsigned total_latency(input int unsigned n_stages,
                                                input int unsigned load_cycles,
                                                input int unsigned inj_cycles,
                                                input int unsigned mix_len,
                                                input int unsigned drain_cycles);
    int unsigned mix_eff;
    mix_eff = (mix_len == 0) ? 1 : mix_len;
    return load_cycles + n_stages * (inj_cycles + mix_eff) + drain_cycles + 1;
  endfunction

endpackage

// File: rtl/chain_mix_sequencer_if.sv
// Host command / actuator bundle of the mixer-chain sequencer.
interface chain_mix_sequencer_if #(
  parameter int unsigned N_STAGES = 8,
  parameter int unsigned CNT_W    = 16
);
  localparam int unsigned StageW = $clog2(N_STAGES) + 1;

  logic                start;
  logic                abort;
  logic [CNT_W-1:0]    mix_len;
  logic                inlet_open;
  logic [N_STAGES-1:0] reagent_open;
  logic [N_STAGES-1:0] mixer_en;
  logic                outlet_open;
  logic [StageW-1:0]   stage_idx;
  logic                busy;
  logic                done;
  logic                aborted;

  modport master (
    output start, abort, mix_len,
    input  inlet_open, reagent_open, mixer_en, outlet_open, stage_idx, busy, done, aborted
  );

  modport slave (
    input  start, abort, mix_len,
    output inlet_open, reagent_open, mixer_en, outlet_open, stage_idx, busy, done, aborted
  );

endinterface

// File: rtl/chain_mix_sequencer_phase_timer.sv
// Loadable down-counter with a zero flag; parks at zero until reloaded.
module phase_timer #(
  parameter int unsigned CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/chain_mix_sequencer.sv
// Sequencer for the fluidic mixer chain: inlet, per-stage inject/mix, drain.
// All actuator outputs are registered decodes of the next state and stage.
module chain_mix_sequencer
  import chain_mix_pkg::*;
#(
  parameter int unsigned N_STAGES     = 8,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned LOAD_CYCLES  = LoadCyclesDef,
  parameter int unsigned INJ_CYCLES   = InjCyclesDef,
  parameter int unsigned DRAIN_CYCLES = DrainCyclesDef
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  chain_mix_sequencer_if.slave  bus
);

  localparam int unsigned StageW = $clog2(N_STAGES) + 1;
  localparam logic [StageW-1:0]   LastStage = StageW'(N_STAGES - 1);
  localparam logic [N_STAGES-1:0] OneHot0   = N_STAGES'(1);

  state_e              state_q, state_d;
  logic [StageW-1:0]   stage_q, stage_d;
  logic [CNT_W-1:0]    mix_q, mix_d;
  logic                tmr_load, tmr_zero;
  logic [CNT_W-1:0]    tmr_val;
  logic                inlet_q, inlet_d, outlet_q, outlet_d;
  logic [N_STAGES-1:0] reagent_q, reagent_d, mixer_q, mixer_d;
  logic                busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;

  phase_timer #(
    .CntW (CNT_W)
  ) u_phase_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    mix_d     = mix_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    aborted_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          mix_d    = (bus.mix_len == '0) ? CNT_W'(1) : bus.mix_len;
          state_d  = StLoad;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(LOAD_CYCLES - 1);
        end
      end
      StLoad: begin
        if (tmr_zero) begin
          state_d  = StInject;
          stage_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(INJ_CYCLES - 1);
        end
      end
      StInject: begin
        if (tmr_zero) begin
          state_d  = StMix;
          tmr_load = 1'b1;
          tmr_val  = mix_q - 1'b1;
        end
      end
      StMix: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (stage_q < LastStage) begin
            stage_d = stage_q + 1'b1;
            state_d = StInject;
            tmr_val = CNT_W'(INJ_CYCLES - 1);
          end else begin
            state_d = StDrain;
            tmr_val = CNT_W'(DRAIN_CYCLES - 1);
          end
        end
      end
      StDrain: begin
        if (tmr_zero) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
        stage_d = '0;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides every transition, including the one into DONE.
    if (bus.abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      stage_d   = '0;
      aborted_d = 1'b1;
      tmr_load  = 1'b1;
      tmr_val   = '0;
    end
  end

  always_comb begin
    inlet_d   = (state_d == StLoad);
    outlet_d  = (state_d == StDrain);
    reagent_d = (state_d == StInject) ? (OneHot0 << stage_d) : '0;
    mixer_d   = (state_d == StMix) ? (OneHot0 << stage_d) : '0;
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      stage_q   <= '0;
      mix_q     <= '0;
      inlet_q   <= 1'b0;
      outlet_q  <= 1'b0;
      reagent_q <= '0;
      mixer_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      mix_q     <= mix_d;
      inlet_q   <= inlet_d;
      outlet_q  <= outlet_d;
      reagent_q <= reagent_d;
      mixer_q   <= mixer_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.inlet_open   = inlet_q;
  assign bus.outlet_open  = outlet_q;
  assign bus.reagent_open = reagent_q;
  assign bus.mixer_en     = mixer_q;
  assign bus.stage_idx    = stage_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.aborted      = aborted_q;

`ifndef SYNTHESIS
  int unsigned lat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_q <= 0;
    end else if ((state_q == StIdle) && (state_d == StLoad)) begin
      lat_q <= 1;
    end else if (state_q != StIdle) begin
      lat_q <= lat_q + 1;
    end
  end

  // Two actuators open together would cross-contaminate reagents.
  a_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({inlet_q, outlet_q, reagent_q, mixer_q}));

  a_latency: assert property (@(posedge clk_i) disable iff (!rst_ni)
    done_q |-> (lat_q == total_latency(N_STAGES, LOAD_CYCLES, INJ_CYCLES, 32'(mix_q),
                                       DRAIN_CYCLES)));

  a_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    busy_q == (state_q != StIdle));
`endif

endmodule

// File: tb/tb_chain_mix_sequencer.sv
// Directed bench for chain_mix_sequencer: per-cycle trace against a spec model.
module tb_chain_mix_sequencer;
  import chain_mix_pkg::*;

  localparam int unsigned NS = 8;
  localparam int unsigned CW = 16;
  localparam int          AbortBit = 18;

  logic clk_i;
  logic rst_ni;
  int   n_cmp = 0;
  int   n_err = 0;

  chain_mix_sequencer_if #(.N_STAGES(NS), .CNT_W(CW)) bus ();

  chain_mix_sequencer #(
    .N_STAGES     (NS),
    .CNT_W        (CW),
    .LOAD_CYCLES  (LoadCyclesDef),
    .INJ_CYCLES   (InjCyclesDef),
    .DRAIN_CYCLES (DrainCyclesDef)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // {busy, done, aborted, inlet, outlet, reagent[7:0], mixer[7:0]}
  function automatic logic [31:0] pack();
    return 32'({bus.busy, bus.done, bus.aborted, bus.inlet_open, bus.outlet_open,
                bus.reagent_open, bus.mixer_en});
  endfunction

  // Expected outputs in cycle k after the start edge (k=1 is the first LOAD cycle).
  function automatic logic [31:0] exp_vec(input int k, input int mm, input int tot);
    logic       busy, done, inl, outl;
    logic [7:0] rg, mx;
    int         body, per, s, r;
    busy = (k <= tot);
    done = (k == tot);
    inl = 1'b0; outl = 1'b0; rg = '0; mx = '0;
    per  = int'(InjCyclesDef) + mm;
    body = int'(NS) * per;
    if (k >= 1 && k <= int'(LoadCyclesDef)) begin
      inl = 1'b1;
    end else if (k > int'(LoadCyclesDef) && k <= int'(LoadCyclesDef) + body) begin
      s = (k - int'(LoadCyclesDef) - 1) / per;
      r = (k - int'(LoadCyclesDef) - 1) % per;
      if (r < int'(InjCyclesDef)) rg[s] = 1'b1;
      else                        mx[s] = 1'b1;
    end else if (k > int'(LoadCyclesDef) + body && k < tot) begin
      outl = 1'b1;
    end
    return 32'({busy, done, 1'b0, inl, outl, rg, mx});
  endfunction

  // Stage index expected in LOAD/INJECT/MIX; -1 where not checked.
  function automatic int exp_stage(input int k, input int mm);
    int per;
    per = int'(InjCyclesDef) + mm;
    if (k >= 1 && k <= int'(LoadCyclesDef)) return 0;
    if (k > int'(LoadCyclesDef) && k <= int'(LoadCyclesDef) + int'(NS) * per)
      return (k - int'(LoadCyclesDef) - 1) / per;
    return -1;
  endfunction

  // Starts a run in the current cycle; returns at the negedge of the first IDLE cycle.
  task automatic run_seq(input int m, input int abort_k, input int chg_k, input int rst_k);
    int          mm, tot, limit, es;
    logic [31:0] ev;
    bit          seen;
    mm    = (m == 0) ? 1 : m;
    tot   = int'(total_latency(NS, LoadCyclesDef, InjCyclesDef, mm, DrainCyclesDef));
    limit = (abort_k > 0) ? abort_k + 1 : tot + 1;
    bus.mix_len = CW'(m);
    bus.start   = 1'b1;
    bus.abort   = 1'b0;
    @(negedge clk_i);
    bus.start = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      if (k > 1) @(negedge clk_i);
      ev = exp_vec(k, mm, tot);
      es = exp_stage(k, mm);
      if (k == tot + 1) es = 0;
      if (abort_k > 0 && k == abort_k + 1) begin
        ev = 32'(1) << AbortBit;
        es = 0;
      end
      check($sformatf("vec m=%0d k=%0d", m, k), pack(), ev);
      if (es >= 0) check($sformatf("stage m=%0d k=%0d", m, k), 32'(bus.stage_idx), 32'(es));
      if (chg_k > 0 && k == chg_k) begin
        bus.start   = 1'b1;
        bus.mix_len = CW'(50);
      end
      if (chg_k > 0 && k == chg_k + 1) bus.start = 1'b0;
      if (k == abort_k) bus.abort = 1'b1;
      if (k == rst_k) begin
        #2 rst_ni = 1'b0;
        #1;
        check("rst_async_vec", pack(), 32'h0);
        check("rst_async_stage", 32'(bus.stage_idx), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 1'b0;
        repeat (20) begin
          @(negedge clk_i);
          if (bus.done || bus.aborted || bus.busy) seen = 1'b1;
        end
        check("post_rst_quiet", 32'(seen), 32'h0);
        check("post_rst_stage", 32'(bus.stage_idx), 32'h0);
        break;
      end
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      check("onehot", 32'($countones({bus.inlet_open, bus.outlet_open, bus.reagent_open,
                                       bus.mixer_en}) <= 1), 32'h1);
    end
  end

  initial begin
    int  m, ab, tot;
    bit  seen;
    rst_ni      = 1'b0;
    bus.start   = 1'b1;
    bus.abort   = 1'b0;
    bus.mix_len = CW'(7);
    repeat (2) @(negedge clk_i);
    check("reset_vec", pack(), 32'h0);
    check("reset_stage", 32'(bus.stage_idx), 32'h0);
    bus.start = 1'b0;
    rst_ni    = 1'b1;
    @(negedge clk_i);
    check("idle_vec", pack(), 32'h0);

    run_seq(10, 0, 0, 0);           // nominal, done at 105
    run_seq(0, 0, 0, 0);            // zero mix_len -> 1, done at 33
    run_seq(10, 0, 20, 0);          // start/mix_len changes mid-run ignored
    run_seq(3, 0, 0, 0);            // accepted in first IDLE cycle after DONE

    // Abort with start in IDLE: nothing happens.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk_i);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("idle_abort_vec", pack(), 32'h0);
    @(negedge clk_i);
    check("idle_abort_vec2", pack(), 32'h0);

    run_seq(10, 45, 0, 0);          // abort during MIX of stage 3
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk_i);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("post_abort_quiet", 32'(seen), 32'h0);
    run_seq(2, 0, 0, 0);

    run_seq(1, 33, 0, 0);           // abort while in DONE

    run_seq(10, 0, 0, 65);          // reset at first INJECT cycle of stage 5
    run_seq(1, 0, 0, 0);

    repeat (6) begin
      m   = int'($urandom_range(0, 6));
      tot = int'(total_latency(NS, LoadCyclesDef, InjCyclesDef, m, DrainCyclesDef));
      ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, tot)) : 0;
      run_seq(m, ab, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
